// File: rtl/code83y_encoder.sv
// code83y_encoder: one-hot row vector to 3-bit row index encoder.
// The raw row vector is registered, debounced by a stability counter,
// classified (legal one-hot / none / multi-hot), and each new legal index
// is offered to the consumer through a valid/ack handshake. Every output
// is driven straight from a register.
module code83y_encoder #(
    parameter int DATAWIDTH_DATA     = 8,
    parameter int DATAWIDTH_SELECTOR = 3,
    parameter int STABLE_CYCLES      = 4,
    parameter int CNTWIDTH           = 3
) (
    input  logic                          CODE83Y_CLOCK_50,
    input  logic                          CODE83Y_RESET_InLow,
    input  logic [DATAWIDTH_DATA-1:0]     CODE83Y_Data_In,
    input  logic                          CODE83Y_Ack_In,
    output logic [DATAWIDTH_SELECTOR-1:0] CODE83Y_Select_Out,
    output logic                          CODE83Y_Valid_Out,
    output logic                          CODE83Y_Error_Out,
    output logic                          CODE83Y_Change_Out
);

    // Offer handshake states.
    localparam logic [1:0] ST_WAIT_STABLE = 2'd0;
    localparam logic [1:0] ST_OFFER       = 2'd1;
    localparam logic [1:0] ST_WAIT_CHANGE = 2'd2;

    // Classification codes of a stable sample.
    localparam logic [1:0] CLS_NONE  = 2'd0;
    localparam logic [1:0] CLS_LEGAL = 2'd1;
    localparam logic [1:0] CLS_MULTI = 2'd2;

    // Counter value meaning STABLE_CYCLES identical registered samples.
    localparam logic [CNTWIDTH-1:0] CNT_SAT = CNTWIDTH'(STABLE_CYCLES - 1);

    // Zero-hot, one-hot or multi-hot. v & (v-1) clears the lowest set bit,
    // so anything left over means at least two bits were set.
    function automatic logic [1:0] classify(input logic [DATAWIDTH_DATA-1:0] v);
        logic [DATAWIDTH_DATA-1:0] low_cleared;
        low_cleared = v & (v - 1'b1);
        if (v == '0)
            classify = CLS_NONE;
        else if (low_cleared != '0)
            classify = CLS_MULTI;
        else
            classify = CLS_LEGAL;
    endfunction

    // Position of the set bit; only meaningful for a legal one-hot vector.
    function automatic logic [DATAWIDTH_SELECTOR-1:0] encode(input logic [DATAWIDTH_DATA-1:0] v);
        encode = '0;
        for (int i = 0; i < DATAWIDTH_DATA; i++) begin
            if (v[i])
                encode = DATAWIDTH_SELECTOR'(i);
        end
    endfunction

    // Sampling pipeline: samp_p0 is the newest registered input, samp_p1 the
    // one before it. cnt_p1 counts how long samp_p1 has matched its successor.
    logic [DATAWIDTH_DATA-1:0] samp_p0;
    logic [DATAWIDTH_DATA-1:0] samp_p1;
    logic [CNTWIDTH-1:0]       cnt_p1;

    // Handshake state and output registers.
    logic [1:0]                    state;
    logic [DATAWIDTH_SELECTOR-1:0] select_r;
    logic                          valid_r;
    logic                          error_r;
    logic                          change_r;
    logic                          first_offer;
    logic [DATAWIDTH_DATA-1:0]     offered_code;

    // Classification of the debounced sample.
    logic                          stable;
    logic [1:0]                    cls;
    logic [DATAWIDTH_SELECTOR-1:0] idx;
    logic                          is_legal;
    logic                          is_multi;

    // Stage p0 -> p1: register the input and track how long it has held.
    always_ff @(posedge CODE83Y_CLOCK_50) begin
        if (!CODE83Y_RESET_InLow) begin
            samp_p0 <= '0;
            samp_p1 <= '0;
            cnt_p1  <= '0;
        end else begin
            samp_p0 <= CODE83Y_Data_In;
            samp_p1 <= samp_p0;
            if (samp_p0 != samp_p1)
                cnt_p1 <= '0;
            else if (cnt_p1 != CNT_SAT)
                cnt_p1 <= cnt_p1 + 1'b1;
        end
    end

    // Once the counter saturates, samp_p1 has been seen STABLE_CYCLES times
    // in a row, so it is the value that gets classified.
    always_comb begin
        stable   = (cnt_p1 == CNT_SAT);
        cls      = classify(samp_p1);
        idx      = encode(samp_p1);
        is_legal = (cls == CLS_LEGAL);
        is_multi = (cls == CLS_MULTI);
    end

    // Error flag follows the stable classification and holds while unstable.
    always_ff @(posedge CODE83Y_CLOCK_50) begin
        if (!CODE83Y_RESET_InLow)
            error_r <= 1'b0;
        else if (stable)
            error_r <= is_multi;
    end

    // Offer handshake: wait for a stable legal index, hold it until acked,
    // then wait for a different stable value before offering again.
    always_ff @(posedge CODE83Y_CLOCK_50) begin
        if (!CODE83Y_RESET_InLow) begin
            state        <= ST_WAIT_STABLE;
            select_r     <= '0;
            valid_r      <= 1'b0;
            change_r     <= 1'b0;
            first_offer  <= 1'b1;
            offered_code <= '0;
        end else begin
            change_r <= 1'b0;
            case (state)
                ST_WAIT_STABLE: begin
                    valid_r <= 1'b0;
                    if (stable && is_legal) begin
                        select_r     <= idx;
                        offered_code <= samp_p1;
                        valid_r      <= 1'b1;
                        change_r     <= (idx != select_r) || first_offer;
                        first_offer  <= 1'b0;
                        state        <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    // select_r is deliberately untouched here: the consumer
                    // sees a frozen index for the whole offer.
                    if (CODE83Y_Ack_In) begin
                        valid_r <= 1'b0;
                        state   <= ST_WAIT_CHANGE;
                    end
                end
                ST_WAIT_CHANGE: begin
                    valid_r <= 1'b0;
                    // Ack is ignored here; only a different stable value
                    // (other index, zero-hot or multi-hot) re-arms the offer.
                    if (stable && (samp_p1 != offered_code))
                        state <= ST_WAIT_STABLE;
                end
                default: begin
                    valid_r <= 1'b0;
                    state   <= ST_WAIT_STABLE;
                end
            endcase
        end
    end

    assign CODE83Y_Select_Out = select_r;
    assign CODE83Y_Valid_Out  = valid_r;
    assign CODE83Y_Error_Out  = error_r;
    assign CODE83Y_Change_Out = change_r;

endmodule
